// File: rtl/serial_tx_if.sv
// rtl/serial_tx_if.sv - host write port, status flags and serial line of serial_tx
interface serial_tx_if;
    logic [7:0] tx_byte;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_busy;
    logic       tx_ovf;
    logic       tx;

    modport master (
        output tx_byte,
        output tx_wr,
        input  tx_full,
        input  tx_busy,
        input  tx_ovf,
        input  tx
    );

    modport slave (
        input  tx_byte,
        input  tx_wr,
        output tx_full,
        output tx_busy,
        output tx_ovf,
        output tx
    );
endinterface

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - FIFO-buffered 8N1 UART transmitter (8E1 when SERIAL_TX_PARITY_EN is defined)
module serial_tx #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int BAUD    = 115200,
    parameter int FIFO_AW = 2
) (
    input logic        clk,
    input logic        rst,
    serial_tx_if.slave bus
);
    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CW    = $clog2(DIV);
    localparam int DEPTH = 2 ** FIFO_AW;

    localparam logic [CW-1:0]    BAUD_LOAD = CW'(DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef SERIAL_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW:0]   count_n;
    logic [7:0]         head;
    logic               push;
    logic               pop;
    logic               nonempty;

    state_t   state, state_n;
    logic [7:0]    shift, shift_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [CW-1:0] baud, baud_n;
    logic          tick;
    logic          tx_n;
`ifdef SERIAL_TX_PARITY_EN
    logic          par, par_n;
`endif

    // Full is judged on the registered count, so a pop in the same cycle does not rescue a write.
    assign push     = bus.tx_wr && (count != DEPTH_CNT);
    assign nonempty = (count != '0);
    assign head     = mem[rd_ptr];
    assign tick     = (baud == '0);

    // Occupancy bookkeeping: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_n = count;
        if (push && !pop) begin
            count_n = count + 1'b1;
        end else if (!push && pop) begin
            count_n = count - 1'b1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.tx_byte;
        end
    end

    // FIFO pointers, count and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            bus.tx_full <= 1'b0;
            bus.tx_ovf  <= 1'b0;
            bus.tx_busy <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_n;
            bus.tx_full <= (count_n == DEPTH_CNT);
            bus.tx_ovf  <= bus.tx_wr && (count == DEPTH_CNT);
            bus.tx_busy <= (state != S_IDLE) || nonempty;
        end
    end

    // Frame sequencer state, shifter, bit index, baud counter and registered line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_idx <= '0;
            baud    <= '0;
            bus.tx  <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            baud    <= baud_n;
            bus.tx  <= tx_n;
`ifdef SERIAL_TX_PARITY_EN
            par     <= par_n;
`endif
        end
    end

    // Next-state logic; the line value is derived from the next state so tx changes on the same edge as the state.
    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        baud_n    = baud;
        pop       = 1'b0;
        tx_n      = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
        par_n     = par;
`endif
        if (state != S_IDLE) begin
            baud_n = tick ? BAUD_LOAD : baud - 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (nonempty) begin
                    pop     = 1'b1;
                    shift_n = head;
                    baud_n  = BAUD_LOAD;
                    state_n = S_START;
`ifdef SERIAL_TX_PARITY_EN
                    par_n   = ^head;
`endif
                end
            end
            S_START: begin
                if (tick) begin
                    state_n   = S_DATA;
                    bit_idx_n = 3'd0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_n   = {1'b0, shift[7:1]};
                    bit_idx_n = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (tick) begin
                    if (nonempty) begin
                        pop     = 1'b1;
                        shift_n = head;
                        state_n = S_START;
`ifdef SERIAL_TX_PARITY_EN
                        par_n   = ^head;
`endif
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        case (state_n)
            S_START:  tx_n = 1'b0;
            S_DATA:   tx_n = shift_n[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: tx_n = par_n;
`endif
            default:  tx_n = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - scoreboard bench for serial_tx (define SERIAL_TX_PARITY_EN for 8E1 frames)
module tb_serial_tx;
    localparam int DIV = 16;    // 1_000_000 / 62_000 truncated
`ifdef SERIAL_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] b;
        logic       par;
        bit         contig;
        bit         aborted;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    serial_tx_if bus ();

    serial_tx #(
        .CLK_HZ (1_000_000),
        .BAUD   (62_000),
        .FIFO_AW(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic par, input bit contig, input bit aborted);
        exp_t e;
        e.b = b; e.par = par; e.contig = contig; e.aborted = aborted;
        q.push_back(e);
    endtask

    task automatic write(input logic [7:0] b);
        bus.tx_byte = b;
        bus.tx_wr   = 1'b1;
        step();
        bus.tx_wr   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (bus.tx_busy && k < 40 * NB * DIV) begin
            step();
            k++;
        end
        check(name, {31'd0, bus.tx_busy}, 32'd0);
    endtask

    // Monitor: recovers frames from the line and scores them against the expectation queue.
    initial begin
        int unsigned cyc, start_cyc, end_cyc;
        bit          have_end, aborted, stable;
        logic [10:0] obs, want;
        exp_t        e;
        cyc = 0;
        have_end = 0;
        end_cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && bus.tx === 1'b0) begin
                start_cyc = cyc;
                aborted = 0;
                stable = 1;
                obs = '1;
                for (int s = 0; s < NB * DIV; s++) begin
                    if (s > 0) begin
                        @(negedge clk);
                        cyc++;
                    end
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    if (s % DIV == 0) obs[s / DIV] = bus.tx;
                    else if (bus.tx !== obs[s / DIV]) stable = 0;
                end
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_frame: got bits 0x%0h, expected no frame", obs);
                end else begin
                    e = q.pop_front();
                    check("frame_aborted", {31'd0, aborted}, {31'd0, e.aborted});
                    if (!aborted && !e.aborted) begin
                        want = '1;
                        want[0] = 1'b0;
                        want[8:1] = e.b;
`ifdef SERIAL_TX_PARITY_EN
                        want[9] = e.par;
`endif
                        check($sformatf("frame_bits_%02h", e.b), {21'd0, obs}, {21'd0, want});
                        check($sformatf("bit_width_%02h", e.b), {31'd0, stable}, 32'd1);
                        if (e.contig)
                            check($sformatf("gap_%02h", e.b), have_end ? start_cyc - end_cyc - 1 : 32'hffff, 32'd0);
                    end
                end
                end_cyc = cyc;
                have_end = !aborted;
            end
        end
    end

    // Global bound so the run always ends with its summary line.
    initial begin
        repeat (30000) @(posedge clk);
        fails++;
        $display("FAIL watchdog: got no completion, expected finish within 30000 cycles");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        int k, bad;
        // Reset while the host is trying to write a 0x00 byte; nothing may be sent.
        bus.tx_byte = 8'h00;
        bus.tx_wr   = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        check("rst_tx", {31'd0, bus.tx}, 32'd1);
        check("rst_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("rst_full", {31'd0, bus.tx_full}, 32'd0);
        check("rst_ovf", {31'd0, bus.tx_ovf}, 32'd0);
        bus.tx_wr = 1'b0;
        rst = 1'b0;
        repeat (4) step();
        check("idle_tx", {31'd0, bus.tx}, 32'd1);
        check("idle_busy", {31'd0, bus.tx_busy}, 32'd0);

        // Single byte 0x53: latency and frame length.
        expect_frame(8'h53, 1'b0, 0, 0);
        write(8'h53);
        check("lat_tx_n", {31'd0, bus.tx}, 32'd1);
        check("lat_busy_n", {31'd0, bus.tx_busy}, 32'd0);
        step();
        check("lat_tx_n1", {31'd0, bus.tx}, 32'd0);
        check("lat_busy_n1", {31'd0, bus.tx_busy}, 32'd1);
        k = 0;
        while (bus.tx_busy && k < 20 * DIV) begin
            step();
            k++;
        end
        check("busy_fall_cycles", k, NB * DIV + 1);

        // Back-to-back bytes give contiguous frames.
        expect_frame(8'h55, 1'b0, 0, 0);
        expect_frame(8'hAA, 1'b0, 1, 0);
        expect_frame(8'h0F, 1'b0, 1, 0);
        write(8'h55);
        write(8'hAA);
        write(8'h0F);
        wait_idle("idle_after_b2b");
        repeat (3) step();

        // Five consecutive writes fill the depth-4 FIFO; a sixth is dropped.
        expect_frame(8'h11, 1'b0, 0, 0);
        expect_frame(8'h12, 1'b0, 1, 0);
        expect_frame(8'h13, 1'b1, 1, 0);
        expect_frame(8'h14, 1'b0, 1, 0);
        expect_frame(8'h15, 1'b1, 1, 0);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            write(8'h11 + 8'(i));
            if (bus.tx_ovf !== 1'b0) bad++;
            if (i == 3) check("full_before_fill", {31'd0, bus.tx_full}, 32'd0);
        end
        check("no_ovf_on_fill", bad, 0);
        check("full_after_fill", {31'd0, bus.tx_full}, 32'd1);
        write(8'h99);
        check("ovf_pulse", {31'd0, bus.tx_ovf}, 32'd1);
        step();
        check("ovf_one_cycle", {31'd0, bus.tx_ovf}, 32'd0);
        check("full_held", {31'd0, bus.tx_full}, 32'd1);
        k = 0;
        while (bus.tx_full && k < 2 * NB * DIV) begin
            step();
            k++;
        end
        check("full_drop_at_start", {31'd0, bus.tx}, 32'd0);
        wait_idle("idle_after_fill");
        repeat (3) step();

        // Reset during data bit 3 aborts the frame and flushes the queued byte.
        expect_frame(8'hC3, 1'b0, 0, 1);
        write(8'hC3);
        write(8'h3C);
        repeat (4 * DIV + DIV / 2 - 1) step();
        rst = 1'b1;
        step();
        check("midrst_tx", {31'd0, bus.tx}, 32'd1);
        check("midrst_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("midrst_full", {31'd0, bus.tx_full}, 32'd0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 12 * DIV; i++) begin
            step();
            if (bus.tx !== 1'b1 || bus.tx_busy !== 1'b0) bad++;
        end
        check("no_frame_after_rst", bad, 0);

        // Parity-relevant bytes: 0x53 (even popcount) and 0x07 (odd popcount).
        expect_frame(8'h53, 1'b0, 0, 0);
        expect_frame(8'h07, 1'b1, 1, 0);
        write(8'h53);
        write(8'h07);
        wait_idle("idle_after_parity");

        k = 0;
        while (q.size() != 0 && k < 4 * DIV) begin
            step();
            k++;
        end
        check("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
